// File: rtl/uart_ram_pkg.sv
// Shared types and helpers for the UART-to-BRAM loader and its sub-blocks.
//   state_t   : loader FSM encoding (IDLE, RX_DATA, RX_ADDR, WRITE)
//   bytes_for : number of whole bytes needed to carry a field of 'width' bits
package uart_ram_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RX_DATA = 2'd1,
        RX_ADDR = 2'd2,
        WRITE   = 2'd3
    } state_t;

    function automatic int unsigned bytes_for(input int unsigned width);
        return (width + 32'd7) / 32'd8;
    endfunction

endpackage

// File: rtl/rx_gap_timer.sv
// Idle-gap watchdog: a down-counter reloaded on every received byte.
//   clk, nrst : clock, async active-low reset
//   run       : count only while high; reloads while low
//   clear     : reload (a byte arrived)
//   expired   : high while running and TIMEOUT_CYCLES-1 idle cycles have elapsed
module rx_gap_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic clk,
    input  logic nrst,
    input  logic run,
    input  logic clear,
    output logic expired
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    // Reload whenever stopped or a byte arrives; hold at zero once expired.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt <= '0;
        end else if (clear || !run) begin
            cnt <= LOAD;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign expired = run && (cnt == '0);

endmodule

// File: rtl/uart_ram_loader.sv
// Assembles received bytes into {data, address} frames and writes them to BRAM.
// Frame order: DATA bytes then ADDR bytes, each field LSB byte first.
//   clk, nrst    : clock, async active-low reset
//   en           : enable; low forces IDLE and clears count/sticky flags
//   rx_ready     : byte valid (rising edge captures one byte)
//   rx_data      : received byte
//   wr_en        : one-cycle BRAM write strobe
//   wr_addr      : BRAM write address (held until next write)
//   wr_data      : BRAM write data (held until next write)
//   word_count   : words written since enable, saturating
//   done         : pulse on a write to MAX_ADDRESS
//   addr_err     : sticky, a frame address exceeded MAX_ADDRESS
//   timeout_err  : sticky, a partial frame was discarded on timeout
module uart_ram_loader
    import uart_ram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 10,
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned MAX_ADDRESS    = 1023,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  en,
    input  logic                  rx_ready,
    input  logic [7:0]            rx_data,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic [ADDR_WIDTH:0]   word_count,
    output logic                  done,
    output logic                  addr_err,
    output logic                  timeout_err
);

    localparam int unsigned DATA_BYTES = bytes_for(DATA_WIDTH);
    localparam int unsigned ADDR_BYTES = bytes_for(ADDR_WIDTH);
    localparam int unsigned DBUF_W     = 8 * DATA_BYTES;
    localparam int unsigned ABUF_W     = 8 * ADDR_BYTES;
    localparam int unsigned MAX_BYTES  = (DATA_BYTES > ADDR_BYTES) ? DATA_BYTES : ADDR_BYTES;
    localparam int unsigned IDX_W      = $clog2(MAX_BYTES) + 1;
    localparam int unsigned CNT_W      = ADDR_WIDTH + 1;

    state_t              state;
    logic                rx_ready_d;
    logic [IDX_W-1:0]    byte_idx;
    logic [DBUF_W-1:0]   data_buf;
    logic [ABUF_W-1:0]   addr_buf;
    logic                capture_c;
    logic                timer_run_c;
    logic                timer_expired_c;
    logic                addr_ok_c;

    // Rising edge of rx_ready marks exactly one new byte.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rx_ready_d <= 1'b0;
        end else begin
            rx_ready_d <= rx_ready;
        end
    end

    assign capture_c   = rx_ready && !rx_ready_d && en;
    assign timer_run_c = en && ((state == RX_DATA) || (state == RX_ADDR));
    // Full-width compare also rejects any set bits above ADDR_WIDTH.
    assign addr_ok_c   = (addr_buf <= ABUF_W'(MAX_ADDRESS));

    rx_gap_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_gap_timer (
        .clk     (clk),
        .nrst    (nrst),
        .run     (timer_run_c),
        .clear   (capture_c),
        .expired (timer_expired_c)
    );

    // Frame assembly FSM with registered BRAM write outputs.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state       <= IDLE;
            byte_idx    <= '0;
            data_buf    <= '0;
            addr_buf    <= '0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            word_count  <= '0;
            done        <= 1'b0;
            addr_err    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            done  <= 1'b0;

            case (state)
                IDLE: begin
                    if (capture_c) begin
                        data_buf[7:0] <= rx_data;
                        byte_idx      <= IDX_W'((DATA_BYTES == 1) ? 0 : 1);
                        state         <= (DATA_BYTES == 1) ? RX_ADDR : RX_DATA;
                    end
                end

                RX_DATA: begin
                    if (capture_c) begin
                        for (int unsigned k = 0; k < DATA_BYTES; k++) begin
                            if (byte_idx == IDX_W'(k)) data_buf[8*k +: 8] <= rx_data;
                        end
                        if (byte_idx == IDX_W'(DATA_BYTES - 1)) begin
                            byte_idx <= '0;
                            state    <= RX_ADDR;
                        end else begin
                            byte_idx <= byte_idx + IDX_W'(1);
                        end
                    end else if (timer_expired_c) begin
                        byte_idx    <= '0;
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end
                end

                RX_ADDR: begin
                    if (capture_c) begin
                        for (int unsigned k = 0; k < ADDR_BYTES; k++) begin
                            if (byte_idx == IDX_W'(k)) addr_buf[8*k +: 8] <= rx_data;
                        end
                        if (byte_idx == IDX_W'(ADDR_BYTES - 1)) begin
                            byte_idx <= '0;
                            state    <= WRITE;
                        end else begin
                            byte_idx <= byte_idx + IDX_W'(1);
                        end
                    end else if (timer_expired_c) begin
                        byte_idx    <= '0;
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end
                end

                WRITE: begin
                    if (addr_ok_c) begin
                        wr_en   <= 1'b1;
                        wr_addr <= addr_buf[ADDR_WIDTH-1:0];
                        wr_data <= data_buf[DATA_WIDTH-1:0];
                        done    <= (addr_buf == ABUF_W'(MAX_ADDRESS));
                        if (word_count != '1) word_count <= word_count + CNT_W'(1);
                    end else begin
                        addr_err <= 1'b1;
                    end
                    // A byte landing here starts the next frame.
                    if (capture_c) begin
                        data_buf[7:0] <= rx_data;
                        byte_idx      <= IDX_W'((DATA_BYTES == 1) ? 0 : 1);
                        state         <= (DATA_BYTES == 1) ? RX_ADDR : RX_DATA;
                    end else begin
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase

            // Disable overrides everything except the strobe of a write already underway.
            if (!en) begin
                state       <= IDLE;
                byte_idx    <= '0;
                word_count  <= '0;
                addr_err    <= 1'b0;
                timeout_err <= 1'b0;
            end
        end
    end

endmodule
